// File: rtl/k_vector_loader_pkg.sv
// ============================================================================
// k_vector_loader_pkg : shared K-vector row type and loader FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef HEAD_DIM
`define HEAD_DIM 64
`endif

`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 4
`endif

package k_vector_loader_pkg;

  localparam int KV_HEAD_DIM = `HEAD_DIM;
  localparam int KV_MAX_ROWS = `MAX_SEQ_LENGTH;

  // Element 0 occupies bits [7:0]; the FIFO and backend PEs use the same layout.
  typedef logic [KV_HEAD_DIM-1:0][7:0] k_vector_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/k_vector_loader.sv
// ============================================================================
// k_vector_loader : packs memory beats into K-vector rows and feeds the K FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module k_vector_loader
  import k_vector_loader_pkg::*;
#(
  parameter int HEAD_DIM   = `HEAD_DIM,
  parameter int BEAT_BYTES = 8,
  parameter int NUM_ROWS   = `MAX_SEQ_LENGTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(NUM_ROWS):0]   num_rows,
  input  logic                        mem_valid,
  input  logic [8*BEAT_BYTES-1:0]     mem_data,
  output logic                        mem_ready,
  input  logic                        sram_ready,
  output logic                        write_enable,
  output logic [8*HEAD_DIM-1:0]       write_data,
  output logic                        busy,
  output logic                        done
);

  localparam int BEATS  = HEAD_DIM / BEAT_BYTES;
  localparam int BEAT_W = 8 * BEAT_BYTES;
  localparam int BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RCW    = $clog2(NUM_ROWS) + 1;

  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [BCW-1:0] ONE_BEAT  = BCW'(1);
  localparam logic [RCW-1:0] MAX_ROWS  = RCW'(NUM_ROWS);
  localparam logic [RCW-1:0] ONE_ROW   = RCW'(1);

  loader_state_t         state;
  loader_state_t         next_state;
  logic [BCW-1:0]        beat_cnt;
  logic [RCW-1:0]        row_cnt;
  logic [RCW-1:0]        rows_tgt;
  logic [8*HEAD_DIM-1:0] row_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    mem_ready    = 1'b0;
    write_enable = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_state = (num_rows == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        mem_ready = 1'b1;
        if (mem_valid && (beat_cnt == LAST_BEAT)) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        write_enable = 1'b1;
        if (sram_ready) begin
          next_state = (row_cnt == (rows_tgt - ONE_ROW)) ? DONE : FILL;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // row_reg only changes on accepted beats in FILL, so it is frozen while WRITE stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      row_cnt  <= '0;
      rows_tgt <= '0;
      row_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rows_tgt <= (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
            beat_cnt <= '0;
            row_cnt  <= '0;
          end
        end
        FILL: begin
          if (mem_valid) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beat_cnt == BCW'(k)) begin
                row_reg[k*BEAT_W +: BEAT_W] <= mem_data;
              end
            end
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + ONE_BEAT;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            row_cnt <= row_cnt + ONE_ROW;
          end
        end
        default: ;
      endcase
    end
  end

  assign write_data = row_reg;

endmodule

`default_nettype wire

// File: tb/tb_k_vector_loader.sv
// ============================================================================
// tb_k_vector_loader : randomized scoreboard bench for k_vector_loader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_k_vector_loader;

  localparam int HD    = 64;
  localparam int BB    = 8;
  localparam int NR    = 4;
  localparam int BEATS = HD / BB;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       num_rows;
  logic             mem_valid;
  logic [8*BB-1:0]  mem_data;
  logic             mem_ready;
  logic             sram_ready;
  logic             write_enable;
  logic [8*HD-1:0]  write_data;
  logic             busy;
  logic             done;

  k_vector_loader #(.HEAD_DIM(HD), .BEAT_BYTES(BB), .NUM_ROWS(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .mem_valid(mem_valid), .mem_data(mem_data), .mem_ready(mem_ready),
    .sram_ready(sram_ready), .write_enable(write_enable), .write_data(write_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8*BB-1:0] beatq[$];
  logic [8*HD-1:0] expq[$];
  int exp_done  = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  int wr_cnt    = 0;
  int wr_last   = 0;
  int wr_prev   = 0;
  int stall_cnt = 0;
  int acc_cnt   = 0;
  int start_cyc = 0;
  int vmode     = 0;
  int smode     = 0;
  int hold_left = 0;
  bit noise     = 1'b0;
  bit tog       = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [8*HD-1:0] act, input logic [8*HD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a row is the byte stream of its beats, byte 0 of the first beat is element 0.
  task automatic plan_load(input int n, input bit pattern);
    int tgt;
    logic [8*HD-1:0] row;
    logic [8*BB-1:0] b;
    tgt = (n > NR) ? NR : n;
    for (int r = 0; r < tgt; r++) begin
      row = '0;
      for (int k = 0; k < BEATS; k++) begin
        b = pattern ? {8{8'(r*BEATS + k)}} : {$urandom, $urandom};
        beatq.push_back(b);
        for (int e = 0; e < BB; e++) row[8*(k*BB + e) +: 8] = b[8*e +: 8];
      end
      expq.push_back(row);
    end
    exp_done++;
  endtask

  task automatic step(input bit st);
    @(negedge clk);
    start = st | (noise && busy && ($urandom_range(1, 0) == 1));
    tog   = ~tog;
    if (beatq.size() > 0) begin
      mem_data = beatq[0];
      case (vmode)
        0:       mem_valid = 1'b1;
        1:       mem_valid = 1'($urandom_range(1, 0));
        default: mem_valid = tog;
      endcase
    end else begin
      mem_valid = 1'($urandom_range(1, 0));
      mem_data  = {$urandom, $urandom};
    end
    if (hold_left > 0 && write_enable) begin
      sram_ready = 1'b0;
      hold_left--;
    end else begin
      sram_ready = (smode == 0) ? 1'b1 : 1'($urandom_range(1, 0));
    end
    #1;
    if (mem_valid && mem_ready && beatq.size() > 0) begin
      void'(beatq.pop_front());
      acc_cnt++;
    end
  endtask

  task automatic run_load(input int n, input bit pattern);
    int d0;
    int guard;
    d0    = done_cnt;
    guard = 0;
    num_rows = 3'(n);
    plan_load(n, pattern);
    step(1'b1);
    start_cyc = cyc;
    while (done_cnt == d0 && guard < 3000) begin
      step(1'b0);
      guard++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL load_timeout: got no done expected done for num_rows=%0d", n);
      beatq.delete();
      expq.delete();
      exp_done = 0;
    end
    repeat (3) step(1'b0);
    check("done_once", done_cnt - d0, 1);
    check("beats_consumed", beatq.size(), 0);
  endtask

  // Monitor: pops expected rows whenever a row transfer occurs and checks protocol rules.
  logic [8*HD-1:0] prev_data;
  bit prev_stall = 1'b0;
  bit prev_done  = 1'b0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (mem_ready || write_enable) check("no_overlap", mem_ready & write_enable, 0);
      if (prev_stall) begin
        check("stall_we", write_enable, 1);
        check("stall_data", write_data, prev_data);
        check("stall_mem_ready", mem_ready, 0);
      end
      if (write_enable && sram_ready) begin
        if (expq.size() == 0) check("unexpected_write", 1, 0);
        else check("row_data", write_data, expq.pop_front());
        wr_cnt++;
        wr_prev = wr_last;
        wr_last = cyc;
      end
      if (done) begin
        check("done_expected", exp_done > 0, 1);
        check("done_rows_written", expq.size(), 0);
        if (exp_done > 0) exp_done--;
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_done) check("busy_after_done", busy, 0);
      prev_stall = write_enable && !sram_ready;
      if (prev_stall) stall_cnt++;
      prev_data = write_data;
      prev_done = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int w0;
    int d0;
    int guard;
    rst = 1'b1; start = 1'b0; num_rows = '0;
    mem_valid = 1'b1; mem_data = '1; sram_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_ready", mem_ready, 0);
    check("rst_write_enable", write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write_data", write_data, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_valid = 1'b0;

    // Two patterned rows, no backpressure
    vmode = 0; smode = 0;
    run_load(2, 1'b1);
    check("t1_row_spacing", wr_last - wr_prev, 9);

    // FIFO full for 5 cycles
    s0 = stall_cnt;
    hold_left = 5;
    run_load(1, 1'b0);
    check("t2_stall_cycles", stall_cnt - s0, 5);

    // Gappy memory beats
    vmode = 2;
    run_load(3, 1'b0);
    vmode = 0;

    // Zero rows and an over-range request
    w0 = wr_cnt;
    run_load(0, 1'b0);
    check("t4_zero_done_latency", done_cyc - start_cyc, 1);
    check("t4_zero_no_write", wr_cnt - w0, 0);
    w0 = wr_cnt;
    run_load(7, 1'b0);
    check("t4_clamped_rows", wr_cnt - w0, 4);

    // Reset during the 3rd beat of row 1
    d0 = done_cnt;
    s0 = acc_cnt;
    num_rows = 3'd3;
    plan_load(3, 1'b0);
    step(1'b1);
    guard = 0;
    while (acc_cnt - s0 < 10 && guard < 200) begin
      step(1'b0);
      guard++;
    end
    check("t5_beats_before_reset", acc_cnt - s0, 10);
    @(negedge clk);
    rst = 1'b1;
    beatq.delete();
    expq.delete();
    exp_done = 0;
    @(negedge clk);
    rst = 1'b0;
    mem_valid = 1'b0;
    #1;
    check("t5_mem_ready", mem_ready, 0);
    check("t5_write_enable", write_enable, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_write_data", write_data, 0);
    check("t5_no_done_pulse", done_cnt - d0, 0);
    run_load(1, 1'b0);

    // start asserted while busy, then a normal patterned load
    noise = 1'b1;
    w0 = wr_cnt;
    run_load(3, 1'b0);
    check("t6_rows_with_noise", wr_cnt - w0, 3);
    noise = 1'b0;
    run_load(2, 1'b1);
    check("t6_row_spacing", wr_last - wr_prev, 9);

    // Randomized loads with random beat gaps and FIFO backpressure
    for (int i = 0; i < 8; i++) begin
      vmode = $urandom_range(2, 0);
      smode = $urandom_range(1, 0);
      w0 = wr_cnt;
      s0 = $urandom_range(7, 0);
      run_load(s0, 1'b0);
      check("rand_row_count", wr_cnt - w0, (s0 > NR) ? NR : s0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
